// File: rtl/compaction_offset_ctrl.sv
// compaction_offset_ctrl: sequences the byte-rotate shifter for stream compaction.
// Latency: one cycle from an accepted beat descriptor to its registered command.
// Backpressure: command held stable while m_ready is low; s_ready drops until it is taken.
//
// Ports:
//   aclk, areset          clock and asynchronous active-high reset
//   s_valid/s_ready       input beat descriptor handshake
//   s_keep, s_last        tkeep and packet-end of the input beat
//   m_valid/m_ready       shifter/merge command handshake
//   m_offset, m_count     rotate amount and number of valid bytes in the beat
//   m_emit, m_wrap        output word completes / bytes spill into the next word
//   m_flush, m_last       emit partial word with no new data / packet end
//   o_err_keep            sticky flag for a non-contiguous tkeep
module compaction_offset_ctrl #(
  parameter int WIDTH        = 512,
  parameter int BYTES        = WIDTH / 8,
  parameter int OFFSET_WIDTH = $clog2(BYTES),
  parameter int CNT_WIDTH    = OFFSET_WIDTH + 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [BYTES-1:0]        s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OFFSET_WIDTH-1:0] m_offset,
  output logic [CNT_WIDTH-1:0]    m_count,
  output logic                    m_emit,
  output logic                    m_wrap,
  output logic                    m_flush,
  output logic                    m_last,
  output logic                    o_err_keep
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] off;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    emit;
    logic                    wrap;
    logic                    flush;
    logic                    last;
  } cmd_t;

  state_t                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] acc_q, acc_d;
  logic                    vld_q, vld_d;
  cmd_t                    cmd_q, cmd_d;
  logic                    err_q, err_d;

  // Beat byte count: length of the run of ones starting at bit 0.
  logic                    keep_run;
  logic [CNT_WIDTH-1:0]    keep_n;
  logic                    keep_gap;

  always_comb begin
    keep_run = 1'b1;
    keep_n   = '0;
    keep_gap = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (!s_keep[i]) begin
        keep_run = 1'b0;
      end else if (keep_run) begin
        keep_n = keep_n + CNT_WIDTH'(1);
      end else begin
        // a set byte after the first hole: keep is not contiguous
        keep_gap = 1'b1;
      end
    end
  end

  // Fill level after appending this beat; one extra bit so acc + BYTES never overflows.
  logic [CNT_WIDTH:0]      sum;
  logic                    sum_emit;
  logic                    sum_wrap;
  logic [OFFSET_WIDTH-1:0] sum_acc;

  assign sum      = {2'b00, acc_q} + {1'b0, keep_n};
  assign sum_emit = (sum >= (CNT_WIDTH + 1)'(BYTES));
  assign sum_wrap = (sum >  (CNT_WIDTH + 1)'(BYTES));
  assign sum_acc  = sum[OFFSET_WIDTH-1:0];   // modulo BYTES

  // The output register can take a new command when empty or being drained this cycle.
  logic out_free;
  logic accept;

  assign out_free = !vld_q || m_ready;
  assign s_ready  = (state_q == ST_RUN) && out_free;
  assign accept   = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    vld_d   = vld_q && !m_ready;
    cmd_d   = cmd_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (accept) begin
          err_d = err_q | keep_gap;
          if (keep_n != '0) begin
            vld_d = 1'b1;
            cmd_d = '{off:   acc_q,
                      cnt:   keep_n,
                      emit:  sum_emit,
                      wrap:  sum_wrap,
                      flush: 1'b0,
                      last:  s_last && (sum_acc == '0)};
            acc_d = sum_acc;
            // residual bytes at packet end need a separate flush command
            if (s_last && (sum_acc != '0)) begin
              state_d = ST_FLUSH;
            end
          end else if (s_last) begin
            // empty last beat: flush a residual directly, or terminate an empty packet
            vld_d = 1'b1;
            cmd_d = '{off:   acc_q,
                      cnt:   '0,
                      emit:  1'b0,
                      wrap:  1'b0,
                      flush: (acc_q != '0),
                      last:  1'b1};
            acc_d = '0;
          end
        end
      end

      ST_FLUSH: begin
        if (out_free) begin
          vld_d   = 1'b1;
          cmd_d   = '{off:   acc_q,
                      cnt:   '0,
                      emit:  1'b0,
                      wrap:  1'b0,
                      flush: 1'b1,
                      last:  1'b1};
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  assign m_valid    = vld_q;
  assign m_offset   = cmd_q.off;
  assign m_count    = cmd_q.cnt;
  assign m_emit     = cmd_q.emit;
  assign m_wrap     = cmd_q.wrap;
  assign m_flush    = cmd_q.flush;
  assign m_last     = cmd_q.last;
  assign o_err_keep = err_q;

endmodule

// File: tb/tb_compaction_offset_ctrl.sv
// Scoreboard bench for compaction_offset_ctrl (BYTES=64).
// Driver feeds beats and pushes expected commands from a fill-level model;
// a monitor pops and compares on every m_valid && m_ready.
module tb_compaction_offset_ctrl;
  localparam int BYTES = 64;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_keep;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  m_offset;
  logic [6:0]  m_count;
  logic        m_emit;
  logic        m_wrap;
  logic        m_flush;
  logic        m_last;
  logic        o_err_keep;

  compaction_offset_ctrl #(.WIDTH(512)) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_offset(m_offset), .m_count(m_count), .m_emit(m_emit), .m_wrap(m_wrap),
    .m_flush(m_flush), .m_last(m_last), .o_err_keep(o_err_keep)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [5:0] off;
    logic [6:0] cnt;
    logic       emit;
    logic       wrap;
    logic       flush;
    logic       last;
  } cmd_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  cmd_t exp_q[$];
  int   m_acc = 0;   // bytes currently in the partial output word
  bit   m_err = 1'b0;
  bit   hold  = 1'b0;
  int   rdy_pct = 100;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: fill-level arithmetic on whole bytes.
  task automatic model_beat(input logic [63:0] k, input bit last, output bit goes_flush);
    int n;
    int sum;
    n = 0;
    goes_flush = 1'b0;
    while (n < BYTES && k[n]) n++;
    if ((k >> n) != 64'd0) m_err = 1'b1;
    if (n > 0) begin
      sum = m_acc + n;
      exp_q.push_back('{off: 6'(m_acc), cnt: 7'(n), emit: (sum >= BYTES), wrap: (sum > BYTES),
                        flush: 1'b0, last: (last && (sum % BYTES == 0))});
      m_acc = sum % BYTES;
      if (last && m_acc != 0) begin
        exp_q.push_back('{off: 6'(m_acc), cnt: 7'd0, emit: 1'b0, wrap: 1'b0, flush: 1'b1, last: 1'b1});
        m_acc = 0;
        goes_flush = 1'b1;
      end
    end else if (last) begin
      exp_q.push_back('{off: 6'(m_acc), cnt: 7'd0, emit: 1'b0, wrap: 1'b0,
                        flush: (m_acc != 0), last: 1'b1});
      m_acc = 0;
    end
  endtask

  // Starts and returns 1 time unit after a rising edge.
  task automatic send_beat(input logic [63:0] k, input bit last, input bit chk_flush);
    bit ok;
    bit fl;
    ok = 1'b0;
    s_valid = 1'b1;
    s_keep  = k;
    s_last  = last;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge aclk);
      ok = s_ready;
      @(posedge aclk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: keep=%h not accepted within 500 cycles", k);
    end else begin
      model_beat(k, last, fl);
      if (fl && chk_flush) begin
        @(negedge aclk);
        chk("flush_s_ready", {63'd0, s_ready}, 64'd0);
        @(posedge aclk);
        #1;
      end
    end
  endtask

  function automatic logic [63:0] keep_of(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (n >= 64) ? {64{1'b1}} : ((one << n) - one);
  endfunction

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge aclk);
      #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d commands outstanding", exp_q.size());
    end
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (!hold) m_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: compares presented commands and checks stability under backpressure.
  cmd_t mon_act, mon_prev, mon_exp;
  bit   mon_stall = 1'b0;
  int   mon_idx   = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        mon_stall = 1'b0;
      end else begin
        mon_act = '{off: m_offset, cnt: m_count, emit: m_emit, wrap: m_wrap, flush: m_flush, last: m_last};
        if (mon_stall) chk("hold_stable", {46'd0, m_valid, mon_act}, {46'd0, 1'b1, mon_prev});
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cmd: got off=%0d cnt=%0d with no command expected", m_offset, m_count);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
              bad++;
              $display("FAIL cmd#%0d: got off=%0d cnt=%0d emit=%b wrap=%b flush=%b last=%b expected off=%0d cnt=%0d emit=%b wrap=%b flush=%b last=%b",
                       mon_idx, mon_act.off, mon_act.cnt, mon_act.emit, mon_act.wrap, mon_act.flush, mon_act.last,
                       mon_exp.off, mon_exp.cnt, mon_exp.emit, mon_exp.wrap, mon_exp.flush, mon_exp.last);
            end
          end
          mon_idx++;
        end
        mon_stall = m_valid && !m_ready;
        mon_prev  = mon_act;
      end
    end
  end

  initial begin
    int t0;
    logic [63:0] k;
    areset  = 1'b1;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;

    // reset state
    #3;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_err", {63'd0, o_err_keep}, 64'd0);
    chk("rst_cmd", {46'd0, m_offset, m_count, m_emit, m_wrap, m_flush, m_last}, 64'd0);
    @(negedge aclk);
    #2 areset = 1'b0;
    #1 chk("idle_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge aclk);
    #1;

    // full beat, exact fill
    send_beat(keep_of(64), 1'b1, 1'b1);
    // 40, 40, 48(last): wrap then exact fill, no flush
    send_beat(keep_of(40), 1'b0, 1'b1);
    send_beat(keep_of(40), 1'b0, 1'b1);
    send_beat(keep_of(48), 1'b1, 1'b1);
    // 10, 20(last): residual 30 flushed
    send_beat(keep_of(10), 1'b0, 1'b1);
    send_beat(keep_of(20), 1'b1, 1'b1);
    drain();

    // backpressure: m_ready low for 5 edges with beats waiting
    hold = 1'b1;
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(keep_of(12), 1'b0, 1'b1);
        send_beat(keep_of(16), 1'b1, 1'b1);
      end
      begin
        @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
          @(negedge aclk);
          chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
        end
        @(posedge aclk);
        #1;
        hold = 1'b0;
        m_ready = 1'b1;
      end
    join
    // one beat per cycle when m_ready stays high
    t0 = cyc;
    for (int i = 0; i < 4; i++) send_beat(keep_of(8), 1'b0, 1'b1);
    chk("throughput_cycles", 64'(cyc - t0), 64'd4);
    drain();

    // non-contiguous keep, zero-byte beats
    send_beat(64'h0F0F, 1'b1, 1'b1);
    send_beat(64'd0, 1'b1, 1'b1);
    send_beat(keep_of(5), 1'b0, 1'b1);
    send_beat(64'd0, 1'b0, 1'b1);
    send_beat(64'd0, 1'b1, 1'b1);
    drain();
    chk("err_set", {63'd0, o_err_keep}, 64'd1);

    // random traffic with random backpressure
    rdy_pct = 70;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) k = {$urandom, $urandom};
      else k = keep_of($urandom_range(64));
      send_beat(k, ($urandom_range(3) == 0), 1'b1);
    end
    rdy_pct = 100;
    drain();
    chk("err_sticky", {63'd0, o_err_keep}, {63'd0, m_err});

    // reset while in FLUSH with 30 bytes pending
    send_beat(keep_of(10), 1'b0, 1'b1);
    send_beat(keep_of(20), 1'b1, 1'b0);
    hold = 1'b1;
    m_ready = 1'b0;
    @(negedge aclk);
    chk("pre_rst_m_valid", {63'd0, m_valid}, 64'd1);
    chk("pre_rst_s_ready", {63'd0, s_ready}, 64'd0);
    #2 areset = 1'b1;
    #1;
    chk("async_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("async_rst_cmd", {46'd0, m_offset, m_count, m_emit, m_wrap, m_flush, m_last}, 64'd0);
    chk("async_rst_err", {63'd0, o_err_keep}, 64'd0);
    exp_q.delete();
    m_acc = 0;
    m_err = 1'b0;
    @(negedge aclk);
    #2 areset = 1'b0;
    hold = 1'b0;
    @(posedge aclk);
    #1;
    m_ready = 1'b1;
    send_beat(keep_of(8), 1'b1, 1'b1);
    drain();
    chk("err_after_rst", {63'd0, o_err_keep}, 64'd0);
    repeat (3) @(posedge aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compaction_offset_ctrl.md
Name: compaction_offset_ctrl

Overview:
- Sequencer for the byte-rotate shifter pipeline used in stream compaction.
- For each input beat it computes the rotate offset that packs the beat's valid bytes directly behind the bytes already held in the partial output word.
- It also tells the downstream merge stage when an output word completes, when bytes spill into the next word, and when to flush a partial word at packet end.
- Sits between the input AXI4S tkeep sideband tap and the shifter's offset input / merge logic.

Parameters:
- WIDTH, 512: datapath width in bits.
- BYTES, WIDTH/8: bytes per beat.
- OFFSET_WIDTH, $clog2(BYTES): width of the rotate offset.
- CNT_WIDTH, OFFSET_WIDTH+1: width of byte counts (holds 0..BYTES).

Ports:
- aclk  in  1  single clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat descriptor valid.
- s_ready  out  1  descriptor accepted when s_valid && s_ready.
- s_keep  in  BYTES  tkeep of the input beat.
- s_last  in  1  beat is the last of its packet.
- m_valid  out  1  command valid.
- m_ready  in  1  command consumed when m_valid && m_ready.
- m_offset  out  OFFSET_WIDTH  rotate amount (bytes) for the shifter.
- m_count  out  CNT_WIDTH  valid bytes in this beat.
- m_emit  out  1  the output word completes with this beat.
- m_wrap  out  1  some of this beat's bytes spill into the next output word.
- m_flush  out  1  emit the partial word now (no new data).
- m_last  out  1  packet end.
- o_err_keep  out  1  sticky flag: a non-contiguous tkeep was seen.

Behaviour:
- Reset: the interface is one clock (aclk) with asynchronous, active-high reset (areset). While areset is high, all outputs, acc and the FSM go to 0/IDLE immediately. Asserting areset mid-packet discards the pending command and the accumulated residual; no flush is issued.
- acc: OFFSET_WIDTH register holding the number of bytes currently in the partial output word.
- n (count of a beat): length of the run of ones starting at s_keep[0].
  - If any 1 appears above that run, set o_err_keep; it is cleared only by reset.
  - n = BYTES when s_keep is all ones.
- Command generation for an accepted beat with n>0, using sum = acc + n (CNT_WIDTH+1 bits):
  - m_offset = acc, m_count = n.
  - m_emit = (sum >= BYTES); m_wrap = (sum > BYTES).
  - acc <= sum mod BYTES.
- Latency: a command is registered and appears the cycle after the beat is accepted. It is held stable until m_ready.
- s_ready = (state==RUN) && (!m_valid || m_ready). This allows a full-throughput handoff of one beat per cycle.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on the first cycle after reset deasserts; IDLE exists only as the reset state.
  - RUN, accepted beat with s_last=1 and new acc==0: command carries m_last=1; stay in RUN; acc=0.
  - RUN, accepted beat with s_last=1 and new acc!=0: command carries m_last=0; go to FLUSH.
  - FLUSH: once the prior command is consumed or m_ready is high, issue m_flush=1, m_last=1, m_count=0, m_offset=acc, m_emit=0, m_wrap=0. Then set acc=0 and return to RUN. s_ready=0 throughout FLUSH.
- Zero-byte beats (n=0):
  - With s_last=0: consumed, no command issued, acc unchanged.
  - With s_last=1 and acc!=0: a single flush command is issued directly (m_flush=1, m_last=1).
  - With s_last=1 and acc==0: a command with count=0, m_last=1, flush=0 is issued (empty-packet terminator).
- Backpressure: while m_valid && !m_ready, m_* and acc are frozen.
- Wrap-around: acc arithmetic is modulo BYTES; exact fill (sum==BYTES) gives emit=1, wrap=0, acc=0.

Test Plan (BYTES=64):
- Reset, then a single full beat keep=all ones, last=1 -> one command: offset=0, count=64, emit=1, wrap=0, last=1, flush=0; acc=0.
- Beats of 40,40,48 bytes, last on the third -> commands:
  - offset 0, count 40, emit 0;
  - offset 40, count 40, emit 1, wrap 1;
  - offset 16, count 48, emit 1, wrap 0, last 1.
  - No flush follows.
- Beats of 10 then 20 (last) -> commands offset 0/count 10 and offset 10/count 20/last 0, then a flush command with offset=30, count=0, flush=1, last=1. s_ready=0 during FLUSH.
- Hold m_ready=0 for 5 cycles with s_valid high -> m_* stable, s_ready=0 after the first accept, no beat lost; the sequence resumes at one beat per cycle when m_ready=1.
- keep=0x0F0F -> count=4, o_err_keep=1 and it stays set; a zero-byte last beat with acc==0 -> count=0, last=1, flush=0.
- Assert areset asynchronously while in FLUSH with acc=30 -> m_valid drops immediately, acc=0. After release, the next 8-byte beat yields offset=0.
